// File: rtl/uart_num_sender.sv
// uart_num_sender
//   Prints a latched binary word as ASCII (hex or decimal, most-significant digit first) into
//   the UART TX FIFO, one byte per push, with optional leading-zero suppression and an
//   optional CR/LF terminator.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   i_start       one-cycle start pulse; accepted only when idle
//   i_data        value to print, latched on an accepted start
//   i_dec         radix, 1=decimal 0=hex, latched with i_data
//   i_lzs         1=suppress leading zeros, latched with i_data
//   tx_full       TX FIFO full; stalls the byte stream
//   tx_push       push strobe, one byte per asserted cycle
//   tx_push_data  ASCII byte, valid while tx_push=1
//   o_busy        high while a transfer is in progress (including the done cycle)
//   o_done        one-cycle pulse after the last byte has been pushed
module uart_num_sender #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEC_DIG = 5,
    parameter bit          TERM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dec,
    input  logic              i_lzs,
    input  logic              tx_full,
    output logic              tx_push,
    output logic [7:0]        tx_push_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned HEX_DIG = (DATA_W + 3) / 4;
    localparam int unsigned MAX_DIG = (HEX_DIG > DEC_DIG) ? HEX_DIG : DEC_DIG;
    localparam int unsigned DIG_W   = 4 * MAX_DIG;
    localparam int unsigned IDX_W   = $clog2(MAX_DIG);
    localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {StIdle, StConv, StSend, StTerm, StDone} state_e;

    state_e state_q, state_d;

    // dig_q holds either hex nibbles or BCD digits; digit i sits in bits [4i+3:4i].
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              lzs_q, lzs_d;
    logic              seen_q, seen_d;
    logic              term_q, term_d;

    logic [3:0]       cur_dig;
    logic [DIG_W-1:0] dig_adj;
    logic             suppress;
    logic             advance;
    logic             last_dig;
    logic             conv_last;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign cur_dig   = dig_q[{idx_q, 2'b00} +: 4];
    assign last_dig  = (idx_q == '0);
    assign conv_last = (cnt_q == CNT_W'(DATA_W - 1));
    // Digit 0 is never skipped so a zero value still prints one character.
    assign suppress  = (state_q == StSend) && lzs_q && !seen_q && (cur_dig == 4'd0) && !last_dig;
    // A suppressed digit does not touch the FIFO, so it advances regardless of tx_full.
    assign advance   = tx_push || suppress;

    // Double-dabble correction: +3 on every BCD nibble >= 5 before the shift.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < int'(MAX_DIG); i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = i_dec ? StConv : StSend;
            StConv: if (conv_last) state_d = StSend;
            StSend: if (advance && last_dig) state_d = TERM_EN ? StTerm : StDone;
            StTerm: if (tx_push && term_q) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = 8'h00;
        o_busy       = (state_q != StIdle);
        o_done       = 1'b0;
        unique case (state_q)
            StSend: begin
                tx_push      = !tx_full && !suppress;
                tx_push_data = (cur_dig <= 4'd9) ? (8'h30 + {4'h0, cur_dig})
                                                 : (8'h37 + {4'h0, cur_dig});
            end
            StTerm: begin
                tx_push      = !tx_full;
                tx_push_data = term_q ? 8'h0A : 8'h0D;
            end
            StDone: o_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        dig_d  = dig_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        lzs_d  = lzs_q;
        seen_d = seen_q;
        term_d = term_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    lzs_d  = i_lzs;
                    seen_d = 1'b0;
                    term_d = 1'b0;
                    cnt_d  = '0;
                    if (i_dec) begin
                        dig_d = '0;
                        bin_d = i_data;
                    end else begin
                        dig_d = DIG_W'(i_data);
                        bin_d = '0;
                        idx_d = IDX_W'(HEX_DIG - 1);
                    end
                end
            end
            StConv: begin
                dig_d = (dig_adj << 1) | DIG_W'(bin_q[DATA_W-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (conv_last) idx_d = IDX_W'(DEC_DIG - 1);
            end
            StSend: begin
                if (advance) begin
                    if (cur_dig != 4'd0) seen_d = 1'b1;
                    if (!last_dig) idx_d = idx_q - IDX_W'(1);
                end
            end
            StTerm: if (tx_push) term_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            lzs_q  <= 1'b0;
            seen_q <= 1'b0;
            term_q <= 1'b0;
        end else begin
            dig_q  <= dig_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            lzs_q  <= lzs_d;
            seen_q <= seen_d;
            term_q <= term_d;
        end
    end

endmodule

// File: tb/tb_uart_num_sender.sv
// Testbench for uart_num_sender (DATA_W=16, DEC_DIG=5, TERM_EN=1).
module tb_uart_num_sender;

    localparam int DATA_W  = 16;
    localparam int DEC_DIG = 5;
    localparam int HEX_DIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_data;
    logic        i_dec;
    logic        i_lzs;
    logic        tx_full;
    logic        tx_push;
    logic [7:0]  tx_push_data;
    logic        o_busy;
    logic        o_done;

    uart_num_sender #(
        .DATA_W (DATA_W),
        .DEC_DIG(DEC_DIG),
        .TERM_EN(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_data      (i_data),
        .i_dec       (i_dec),
        .i_lzs       (i_lzs),
        .tx_full     (tx_full),
        .tx_push     (tx_push),
        .tx_push_data(tx_push_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;
    int start_cyc = 0;

    // Monitor: every pushed byte and every done pulse, with the cycle it appeared in.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;

    always @(negedge clk) begin
        if (tx_push) begin
            got_q.push_back(tx_push_data);
            got_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the printed string straight from positional arithmetic.
    // Returns the number of suppressed leading digits.
    function automatic int build_model(input int unsigned v, input bit dec, input bit lzs);
        int          nd;
        int          ns;
        int unsigned d;
        int unsigned p;
        bit          seen;
        exp_q.delete();
        ns   = 0;
        seen = 1'b0;
        nd   = dec ? DEC_DIG : HEX_DIG;
        for (int i = nd - 1; i >= 0; i--) begin
            if (dec) begin
                p = 1;
                for (int k = 0; k < i; k++) p = p * 10;
                d = (v / p) % 10;
            end else begin
                d = (v >> (4 * i)) & 15;
            end
            if (lzs && !seen && d == 0 && i != 0) ns++;
            else exp_q.push_back((d < 10) ? 8'(32'h30 + d) : 8'(32'h37 + d));
            if (d != 0) seen = 1'b1;
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        return ns;
    endfunction

    // bp: 0 = no backpressure, 1 = full for 3 cycles after the 2nd push, 2 = random full.
    // inj: pulse a bogus start (0x9999) mid-transfer.
    task automatic run_xfer(input logic [15:0] v, input bit dec, input bit lzs, input int bp,
                            input bit inj);
        int ns, base, dbase, nd, lat0, held;
        bit injd;
        ns    = build_model(v, dec, lzs);
        base  = got_q.size();
        dbase = done_cnt;
        nd    = dec ? DEC_DIG : HEX_DIG;
        lat0  = dec ? 1 + DATA_W : 1;
        i_data  = v;
        i_dec   = dec;
        i_lzs   = lzs;
        i_start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        i_start   = 1'b0;
        // Operands are latched; scramble the inputs.
        i_data = 16'($urandom);
        i_dec  = 1'($urandom);
        i_lzs  = 1'($urandom);
        check_eq("busy_on", {31'd0, o_busy}, 32'd1);
        held = 0;
        injd = 1'b0;
        for (int k = 0; k < 300 && done_cnt == dbase; k++) begin
            tx_full = 1'b0;
            if (bp == 1 && got_q.size() - base >= 2 && held < 3) begin
                tx_full = 1'b1;
                held++;
            end else if (bp == 2) begin
                tx_full = ($urandom_range(0, 2) == 0);
            end
            i_start = 1'b0;
            if (inj && !injd && got_q.size() - base >= 2) begin
                i_start = 1'b1;
                i_data  = 16'h9999;
                i_dec   = 1'b0;
                i_lzs   = 1'b0;
                injd    = 1'b1;
            end
            @(posedge clk); #1;
        end
        tx_full = 1'b0;
        i_start = 1'b0;
        check_eq("done_seen", done_cnt - dbase, 1);
        check_eq("busy_off", {31'd0, o_busy}, 32'd0);
        check_eq("n_bytes", got_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size() && base + j < got_q.size(); j++)
            check_eq($sformatf("byte%0d", j), {24'd0, got_q[base+j]}, {24'd0, exp_q[j]});
        if (bp != 2) begin
            check_eq("done_lat", done_cyc - start_cyc + 1, lat0 + nd + 2 + ((bp == 1) ? 3 : 0));
            if (got_q.size() > base)
                check_eq("first_lat", got_cyc[base] - start_cyc + 1, lat0 + ns);
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("single_done", done_cnt - dbase, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int base, dbase, rbase, sel;
        logic [15:0] v;
        rst     = 1'b1;
        i_start = 1'b0;
        i_data  = '0;
        i_dec   = 1'b0;
        i_lzs   = 1'b0;
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_push", {31'd0, tx_push}, 32'd0);
        check_eq("rst_data", {24'd0, tx_push_data}, 32'd0);
        check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
        check_eq("rst_done", {31'd0, o_done}, 32'd0);

        run_xfer(16'h12AF, 1'b0, 1'b0, 0, 1'b0);
        run_xfer(16'd65535, 1'b1, 1'b0, 0, 1'b0);
        run_xfer(16'd42, 1'b1, 1'b1, 0, 1'b0);
        run_xfer(16'd0, 1'b1, 1'b1, 0, 1'b0);
        run_xfer(16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_xfer(16'h12AF, 1'b0, 1'b0, 1, 1'b0);
        run_xfer(16'h12AF, 1'b0, 1'b0, 0, 1'b1);
        run_xfer(16'h0BEE, 1'b0, 1'b1, 0, 1'b0);

        // Reset in the middle of a decimal transfer.
        base  = got_q.size();
        dbase = done_cnt;
        i_data  = 16'd65535;
        i_dec   = 1'b1;
        i_lzs   = 1'b0;
        i_start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        i_start   = 1'b0;
        for (int k = 0; k < 100 && got_q.size() - base < 3; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rbase = got_q.size();
        check_eq("rst_mid_push", {31'd0, tx_push}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("rst_pre_bytes", rbase - base, 4);
        check_eq("rst_no_push", got_q.size() - rbase, 0);
        check_eq("rst_no_done", done_cnt - dbase, 0);
        run_xfer(16'd65535, 1'b1, 1'b0, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) v = 16'($urandom_range(0, 15));
            else if (sel == 1) v = 16'($urandom_range(0, 999));
            else v = 16'($urandom);
            run_xfer(v, 1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
